ofs_fim_axi_mmio_csr_bridge: RTL and testbench
==============================================

# ofs_fim_axi_mmio_csr_bridge

AXI4 MMIO slave-side terminator that converts single-beat AXI4 MMIO reads and writes into a simple request/acknowledge CSR bus for a feature register block. It sits directly downstream of an `ofs_fim_axi_mmio_if` slave modport and drives one CSR target. It serialises reads and writes, arbitrates round-robin between them, rejects bursts with SLVERR, and bounds every CSR access with a timeout.

## Interface
- ID_WIDTH, 10, AXI ID width (awid/bid/arid/rid)
- ADDR_WIDTH, 21, AXI byte address width
- DATA_WIDTH, 64, data width; 32 or 64
- TIMEOUT, 256, maximum cycles csr_req waits for csr_ack; must be ≥2

Ports:
- clk  in  1  the single clock; everything in this block is synchronous to it
- rst  in  1  reset; synchronous, active-high
- awvalid/awready  in/out  1  write address handshake
- awid, awaddr, awlen  in  ID_WIDTH, ADDR_WIDTH, 8  write address fields (other AW fields ignored)
- wvalid/wready  in/out  1  write data handshake
- wdata, wstrb, wlast  in  DATA_WIDTH, DATA_WIDTH/8, 1  write data
- bvalid/bready  out/in  1  write response handshake
- bid, bresp  out  ID_WIDTH, 2  write response
- arvalid/arready  in/out  1  read address handshake
- arid, araddr, arlen  in  ID_WIDTH, ADDR_WIDTH, 8  read address fields
- rvalid/rready  out/in  1  read data handshake
- rid, rdata, rresp, rlast  out  ID_WIDTH, DATA_WIDTH, 2, 1  read response
- csr_req  out  1  CSR access request, held until ack or timeout
- csr_wr  out  1  1 = write, 0 = read
- csr_addr  out  ADDR_WIDTH-log2(DATA_WIDTH/8)  word address (byte offset bits dropped)
- csr_wdata, csr_be  out  DATA_WIDTH, DATA_WIDTH/8  write data and byte enables (wstrb)
- csr_ack  in  1  one-cycle completion strobe
- csr_rdata  in  DATA_WIDTH  read data, valid with csr_ack
- csr_err  in  1  target error, valid with csr_ack; produces SLVERR

## Operation
- FSM states: IDLE, W_DATA, W_DRAIN, CSR, B_RESP, R_RESP, R_ERR.
- IDLE: wr_sel = awvalid & (~arvalid | last_grant==READ). awready = IDLE & wr_sel. arready = IDLE & arvalid & ~wr_sel. Both readies are decoded combinationally from registered state; they never both assert.
- AW handshake: capture id/addr/len; last_grant←WRITE. If len==0 → W_DATA, otherwise → W_DRAIN.
- W_DATA: wready=1. Handshake captures wdata/wstrb → CSR with csr_wr=1.
- W_DRAIN: wready=1. Beats are discarded until the wlast handshake → B_RESP with bresp=2'b10.
- AR handshake: capture id/addr/len; last_grant←READ. If len==0 → CSR with csr_wr=0, otherwise → R_ERR.
- CSR: csr_req=1 with fields stable. The timeout counter clears on entry.
  - csr_ack → B_RESP or R_RESP. resp = csr_err ? 2'b10 : 2'b00. rdata←csr_rdata for reads.
  - Counter reaching TIMEOUT-1 with no ack → same exit with resp=2'b10, rdata=0.
- B_RESP: bvalid=1, bid=captured id, held until bready → IDLE.
- R_RESP: rvalid=1, rlast=1, rid=captured id, held until rready → IDLE.
- R_ERR: emits len+1 beats, each rdata=0 and rresp=2'b10. rlast is asserted on the final beat only. Beats advance on rvalid&rready. After the last beat → IDLE.
- wlast is ignored in W_DATA. A csr_ack outside CSR is ignored (late acks after a timeout are dropped). Only one transaction is outstanding at a time.

## Timing
- Reset values:
  - awready, wready, arready, bvalid, rvalid, rlast, csr_req, csr_wr = 0.
  - bresp, rresp, bid, rid, rdata, csr_addr, csr_wdata, csr_be = 0.
  - State = IDLE. last_grant = READ, so a write wins the first conflict.
- Write latency: AW at cycle N; W handshake no earlier than N+1; csr_req rises the cycle after the W handshake; ack at cycle M gives bvalid at M+1.
- Read latency: AR at N; csr_req at N+1; ack at M gives rvalid and rdata at M+1.
- Fastest ack: csr_ack in the first csr_req cycle, so csr_req lasts exactly 1 cycle.
- Timeout: with no ack, csr_req is high for exactly TIMEOUT cycles, and the response valid rises the next cycle.
- csr_req deasserts in the cycle after ack or timeout. It never re-asserts without a new AXI transaction.
- Valid/data outputs are registered and stable while valid && !ready.
- rst asserted mid-transaction: return to IDLE the next cycle and drop the transaction with no response. Every output takes its reset value.

## Test plan
- Single write: awaddr=0x100, awid=5, wdata=0xA5A5_0000_1234_5678, wstrb=0xFF, ack after 3 cycles. Required: csr_addr=0x20, csr_wr=1, csr_be=0xFF; bid=5, bresp=0.
- Single read: araddr=0x1F8, arid=0x3FF, csr_rdata=0xDEAD_BEEF, ack in the first req cycle. Required: csr_addr=0x3F, csr_req high 1 cycle, rdata=0xDEAD_BEEF, rlast=1, rresp=0, rid=0x3FF.
- Simultaneous awvalid+arvalid held for 3 back-to-back transactions each. Required after reset: order W,R,W,R,W,R; awready and arready are never high together.
- Bursts: awlen=3 with 4 W beats gives no csr_req and one B with bresp=2. arlen=2 gives 3 R beats with rresp=2, rdata=0, and rlast only on beat 3.
- Timeout with TIMEOUT=8 and no ack: csr_req high exactly 8 cycles, then rresp=2 and rdata=0. A late csr_ack 5 cycles later has no effect.
- Backpressure and reset: bready held low 10 cycles gives bvalid/bid stable throughout. Asserting rst during CSR gives csr_req=0 the next cycle with no B or R issued.

Source files
------------

// File: rtl/ofs_fim_axi_mmio_csr_bridge.sv
// Single-beat AXI4 MMIO slave to request/acknowledge CSR bus bridge.
// One transaction in flight; round-robin AW/AR arbitration; bursts rejected with SLVERR; CSR accesses time out.
module ofs_fim_axi_mmio_csr_bridge #(
    parameter int ID_WIDTH   = 10,
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 256,
    localparam int BE_WIDTH  = DATA_WIDTH / 8,
    localparam int OFF_WIDTH = $clog2(BE_WIDTH),
    localparam int CSR_AW    = ADDR_WIDTH - OFF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BE_WIDTH-1:0]   wstrb,
    input  logic                  wlast,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  csr_req,
    output logic                  csr_wr,
    output logic [CSR_AW-1:0]     csr_addr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic [BE_WIDTH-1:0]   csr_be,
    input  logic                  csr_ack,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    input  logic                  csr_err
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_W_DATA, S_W_DRAIN, S_CSR, S_B_RESP, S_R_RESP, S_R_ERR
    } state_t;

    state_t                  state_q;
    logic                    last_rd_q;
    logic [7:0]              len_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    bvalid_q, rvalid_q, rlast_q, csr_req_q, csr_wr_q;
    logic [ID_WIDTH-1:0]     bid_q, rid_q;
    logic [1:0]              bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0]   rdata_q, csr_wdata_q;
    logic [CSR_AW-1:0]       csr_addr_q;
    logic [BE_WIDTH-1:0]     csr_be_q;

    logic       wr_sel, csr_timeout, csr_done;
    logic [1:0] csr_resp;
    logic       unused_addr_bits;

    // NOTE: readies are decoded from registered state, so they drop in the same cycle the handshake moves the FSM on.
    assign wr_sel  = awvalid && (!arvalid || last_rd_q);
    assign awready = !rst && (state_q == S_IDLE) && wr_sel;
    assign arready = !rst && (state_q == S_IDLE) && arvalid && !wr_sel;
    assign wready  = !rst && ((state_q == S_W_DATA) || (state_q == S_W_DRAIN));

    assign csr_timeout = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign csr_done    = csr_ack || csr_timeout;
    assign csr_resp    = (csr_ack && !csr_err) ? RESP_OKAY : RESP_SLVERR;

    assign unused_addr_bits = ^{awaddr[OFF_WIDTH-1:0], araddr[OFF_WIDTH-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_rd_q   <= 1'b1;
            len_q       <= '0;
            cnt_q       <= '0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            csr_req_q   <= 1'b0;
            csr_wr_q    <= 1'b0;
            bid_q       <= '0;
            rid_q       <= '0;
            bresp_q     <= '0;
            rresp_q     <= '0;
            rdata_q     <= '0;
            csr_addr_q  <= '0;
            csr_wdata_q <= '0;
            csr_be_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (awready) begin
                        bid_q      <= awid;
                        csr_addr_q <= awaddr[ADDR_WIDTH-1:OFF_WIDTH];
                        last_rd_q  <= 1'b0;
                        state_q    <= (awlen == 8'd0) ? S_W_DATA : S_W_DRAIN;
                    end else if (arready) begin
                        rid_q      <= arid;
                        csr_addr_q <= araddr[ADDR_WIDTH-1:OFF_WIDTH];
                        len_q      <= arlen;
                        last_rd_q  <= 1'b1;
                        if (arlen == 8'd0) begin
                            csr_req_q <= 1'b1;
                            csr_wr_q  <= 1'b0;
                            cnt_q     <= '0;
                            state_q   <= S_CSR;
                        end else begin
                            rvalid_q <= 1'b1;
                            rlast_q  <= 1'b0;
                            rresp_q  <= RESP_SLVERR;
                            rdata_q  <= '0;
                            state_q  <= S_R_ERR;
                        end
                    end
                end
                S_W_DATA: begin
                    if (wvalid) begin
                        csr_wdata_q <= wdata;
                        csr_be_q    <= wstrb;
                        csr_req_q   <= 1'b1;
                        csr_wr_q    <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_CSR;
                    end
                end
                S_W_DRAIN: begin
                    if (wvalid && wlast) begin
                        bvalid_q <= 1'b1;
                        bresp_q  <= RESP_SLVERR;
                        state_q  <= S_B_RESP;
                    end
                end
                S_CSR: begin
                    if (csr_done) begin
                        csr_req_q <= 1'b0;
                        if (csr_wr_q) begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= csr_resp;
                            state_q  <= S_B_RESP;
                        end else begin
                            rvalid_q <= 1'b1;
                            rlast_q  <= 1'b1;
                            rresp_q  <= csr_resp;
                            rdata_q  <= csr_ack ? csr_rdata : '0;
                            state_q  <= S_R_RESP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_B_RESP: begin
                    if (bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                S_R_RESP: begin
                    if (rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                S_R_ERR: begin
                    // len_q counts the beats still owed after the one currently presented
                    if (rready) begin
                        if (rlast_q) begin
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            state_q  <= S_IDLE;
                        end else begin
                            len_q   <= len_q - 8'd1;
                            rlast_q <= (len_q == 8'd1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bvalid    = bvalid_q;
    assign bid       = bid_q;
    assign bresp     = bresp_q;
    assign rvalid    = rvalid_q;
    assign rid       = rid_q;
    assign rdata     = rdata_q;
    assign rresp     = rresp_q;
    assign rlast     = rlast_q;
    assign csr_req   = csr_req_q;
    assign csr_wr    = csr_wr_q;
    assign csr_addr  = csr_addr_q;
    assign csr_wdata = csr_wdata_q;
    assign csr_be    = csr_be_q;

endmodule

// File: tb/tb_ofs_fim_axi_mmio_csr_bridge.sv
// Self-checking bench for ofs_fim_axi_mmio_csr_bridge: directed vector table, hand-written corner
// sequences, and randomized transactions checked against a transaction-level reference model.
module tb_ofs_fim_axi_mmio_csr_bridge;

    localparam int IDW = 10;
    localparam int AW  = 21;
    localparam int DW  = 64;
    localparam int BEW = DW / 8;
    localparam int CAW = AW - 3;
    localparam int TO  = 8;

    logic clk, rst;
    logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic arvalid, arready, rvalid, rready, rlast;
    logic [IDW-1:0] awid, bid, arid, rid;
    logic [AW-1:0]  awaddr, araddr;
    logic [7:0]     awlen, arlen;
    logic [DW-1:0]  wdata, rdata, csr_wdata, csr_rdata;
    logic [BEW-1:0] wstrb, csr_be;
    logic [1:0]     bresp, rresp;
    logic           csr_req, csr_wr, csr_ack, csr_err;
    logic [CAW-1:0] csr_addr;

    ofs_fim_axi_mmio_csr_bridge #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .csr_req(csr_req), .csr_wr(csr_wr), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_be(csr_be), .csr_ack(csr_ack), .csr_rdata(csr_rdata), .csr_err(csr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit             wr;
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [DW-1:0]  wdata;
        logic [BEW-1:0] wstrb;
        int             ack_dly;   // ack in this req cycle (0 = first); out of range = never
        bit             err;
        logic [DW-1:0]  rdata_in;
    } txn_t;

    typedef struct {
        logic [CAW-1:0] csr_addr;
        logic           csr_wr;
        logic [DW-1:0]  csr_wdata;
        logic [BEW-1:0] csr_be;
        int             req_cycles;
        int             req_wait;
        int             first_valid;
        logic [IDW-1:0] id;
        logic [1:0]     resp;
        logic [DW-1:0]  rdata;
        int             beats;
        logic [15:0]    rlast_mask;
        bit             stable;
        bit             resp_same;
    } obs_t;

    typedef struct {
        txn_t           t;
        logic [CAW-1:0] e_addr;
        int             e_req;
        logic [1:0]     e_resp;
        logic [DW-1:0]  e_rdata;
        int             e_beats;
        logic [15:0]    e_mask;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int both_ready_cnt = 0;

    always @(negedge clk) if (awready && arready) both_ready_cnt++;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        csr_ack   = 1'b0;
        csr_err   = 1'b0;
        bready    = 1'b0;
        rready    = 1'b0;
        csr_rdata = {$urandom, $urandom};
    endtask

    function automatic logic [255:0] all_outs();
        return 256'({awready, wready, arready, bvalid, rvalid, rlast, csr_req, csr_wr,
                     bresp, rresp, bid, rid, rdata, csr_addr, csr_wdata, csr_be});
    endfunction

    // Reference model: what one isolated transaction must look like from the outside.
    function automatic obs_t model(input txn_t t);
        obs_t e;
        bit   acked;
        e = '{default: 0};
        e.stable    = 1'b1;
        e.resp_same = 1'b1;
        acked        = (t.len == 8'd0) && (t.ack_dly >= 0) && (t.ack_dly < TO);
        e.id         = t.id;
        e.csr_wr     = t.wr;
        e.csr_addr   = CAW'(t.addr >> 3);
        e.csr_be     = t.wstrb;
        e.csr_wdata  = t.wdata;
        e.req_cycles = (t.len != 8'd0) ? 0 : (acked ? t.ack_dly + 1 : TO);
        e.first_valid = e.req_cycles;
        e.resp       = (acked && !t.err) ? 2'b00 : 2'b10;
        e.rdata      = (!t.wr && acked) ? t.rdata_in : '0;
        e.beats      = t.wr ? 0 : int'(t.len) + 1;
        e.rlast_mask = t.wr ? 16'd0 : (16'd1 << (e.beats - 1));
        return e;
    endfunction

    task automatic compare(input string tag, input txn_t t, input obs_t o, input obs_t e);
        check({tag, ".req_cycles"}, 256'(o.req_cycles), 256'(e.req_cycles));
        check({tag, ".resp_latency"}, 256'(o.first_valid), 256'(e.first_valid));
        check({tag, ".id"}, 256'(o.id), 256'(e.id));
        check({tag, ".resp"}, 256'(o.resp), 256'(e.resp));
        check({tag, ".stable"}, 256'(o.stable), 256'(e.stable));
        if (t.len == 8'd0) begin
            check({tag, ".csr_addr"}, 256'(o.csr_addr), 256'(e.csr_addr));
            check({tag, ".csr_wr"}, 256'(o.csr_wr), 256'(e.csr_wr));
            check({tag, ".req_wait"}, 256'(o.req_wait), 256'(e.req_wait));
            if (t.wr) begin
                check({tag, ".csr_be"}, 256'(o.csr_be), 256'(e.csr_be));
                check({tag, ".csr_wdata"}, 256'(o.csr_wdata), 256'(e.csr_wdata));
            end
        end
        if (!t.wr) begin
            check({tag, ".rdata"}, 256'(o.rdata), 256'(e.rdata));
            check({tag, ".beats"}, 256'(o.beats), 256'(e.beats));
            check({tag, ".rlast_mask"}, 256'(o.rlast_mask), 256'(e.rlast_mask));
            check({tag, ".resp_same"}, 256'(o.resp_same), 256'(e.resp_same));
        end
    endtask

    task automatic addr_phase(input txn_t t);
        bit hs;
        int n;
        if (t.wr) begin
            awvalid = 1'b1; awid = t.id; awaddr = t.addr; awlen = t.len;
        end else begin
            arvalid = 1'b1; arid = t.id; araddr = t.addr; arlen = t.len;
        end
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 20) begin
            @(negedge clk);
            hs = t.wr ? awready : arready;
            tick();
            n++;
        end
        awvalid = 1'b0;
        arvalid = 1'b0;
        check("addr_handshake", 256'(hs), 256'(1));
    endtask

    // Runs write data, CSR target and response phases; bp = cycles each response beat is held off.
    task automatic finish_txn(input txn_t t, input int bp, output obs_t o);
        bit             hs, done, req_seen, resp_seen, valid;
        int             n, cyc, wait_cnt;
        logic [127:0]   snap, beat_snap;
        o = '{default: 0};
        o.stable    = 1'b1;
        o.resp_same = 1'b1;
        if (t.wr) begin
            hs = 1'b1;
            for (int b = 0; b <= int'(t.len); b++) begin
                wvalid = 1'b1; wdata = t.wdata; wstrb = t.wstrb; wlast = (b == int'(t.len));
                hs = 1'b0;
                n  = 0;
                while (!hs && n < 20) begin
                    @(negedge clk);
                    hs = wready;
                    tick();
                    n++;
                end
                if (!hs) break;
            end
            wvalid = 1'b0;
            wlast  = 1'b0;
            check("w_handshake", 256'(hs), 256'(1));
        end
        done = 1'b0; req_seen = 1'b0; resp_seen = 1'b0; cyc = 0; wait_cnt = 0; beat_snap = '0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (csr_req) begin
                if (!req_seen) begin
                    o.req_wait  = cyc;
                    o.csr_addr  = csr_addr;
                    o.csr_wr    = csr_wr;
                    o.csr_wdata = csr_wdata;
                    o.csr_be    = csr_be;
                end
                req_seen = 1'b1;
                if (o.req_cycles == t.ack_dly) begin
                    csr_ack = 1'b1; csr_err = t.err; csr_rdata = t.rdata_in;
                end
                o.req_cycles++;
            end
            valid = t.wr ? bvalid : rvalid;
            if (valid) begin
                snap = t.wr ? 128'({bid, bresp}) : 128'({rid, rdata, rresp, rlast});
                if (!resp_seen) o.first_valid = cyc;
                resp_seen = 1'b1;
                if (wait_cnt == 0) beat_snap = snap;
                else if (snap !== beat_snap) o.stable = 1'b0;
                if (wait_cnt >= bp) begin
                    if (t.wr) begin
                        bready = 1'b1;
                        o.id   = bid;
                        o.resp = bresp;
                        done   = 1'b1;
                    end else begin
                        rready = 1'b1;
                        if (o.beats == 0) begin
                            o.id   = rid;
                            o.resp = rresp;
                        end else if (rresp !== o.resp) begin
                            o.resp_same = 1'b0;
                        end
                        o.rdata |= rdata;
                        if (rlast) o.rlast_mask[o.beats] = 1'b1;
                        o.beats++;
                        if (rlast || o.beats >= 16) done = 1'b1;
                    end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (resp_seen) begin
                o.stable = 1'b0;
            end
            tick();
            cyc++;
        end
        check("txn_complete", 256'(done), 256'(1));
    endtask

    task automatic run_txn(input txn_t t, input int bp, output obs_t o);
        addr_phase(t);
        finish_txn(t, bp, o);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input bit wr, input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                                input logic [7:0] len, input logic [DW-1:0] wd, input logic [BEW-1:0] be,
                                input int dly, input bit err, input logic [DW-1:0] rd,
                                input logic [CAW-1:0] e_addr, input int e_req, input logic [1:0] e_resp,
                                input logic [DW-1:0] e_rdata, input int e_beats, input logic [15:0] e_mask);
        vec_t v;
        v.t = '{wr: wr, id: id, addr: addr, len: len, wdata: wd, wstrb: be,
                ack_dly: dly, err: err, rdata_in: rd};
        v.e_addr = e_addr; v.e_req = e_req; v.e_resp = e_resp;
        v.e_rdata = e_rdata; v.e_beats = e_beats; v.e_mask = e_mask;
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        obs_t o, e;
        bit   hw, hr, exp_wr, last_rd;
        int   n, cnt;

        vecs[0] = mk(1, 10'h5,   21'h100,    8'd0, 64'hA5A5_0000_1234_5678, 8'hFF, 3, 0, 64'h0,
                     18'h20, 4, 2'b00, 64'h0, 0, 16'h0);
        vecs[1] = mk(0, 10'h3FF, 21'h1F8,    8'd0, 64'h0, 8'h00, 0, 0, 64'hDEAD_BEEF,
                     18'h3F, 1, 2'b00, 64'hDEAD_BEEF, 1, 16'h1);
        vecs[2] = mk(0, 10'h2A,  21'h18,     8'd0, 64'h0, 8'h00, 2, 1, 64'h5555,
                     18'h3, 3, 2'b10, 64'h5555, 1, 16'h1);
        vecs[3] = mk(1, 10'h1,   21'h1FFFF8, 8'd0, 64'h0123_4567_89AB_CDEF, 8'h0F, 1, 1, 64'h0,
                     18'h3FFFF, 2, 2'b10, 64'h0, 0, 16'h0);
        vecs[4] = mk(0, 10'h7,   21'h40,     8'd0, 64'h0, 8'h00, -1, 0, 64'h9999,
                     18'h8, 8, 2'b10, 64'h0, 1, 16'h1);
        vecs[5] = mk(1, 10'h9,   21'h10,     8'd0, 64'h1, 8'h01, 7, 0, 64'h0,
                     18'h2, 8, 2'b00, 64'h0, 0, 16'h0);
        vecs[6] = mk(1, 10'h11,  21'h200,    8'd3, 64'hFFFF, 8'hFF, 0, 0, 64'h0,
                     18'h40, 0, 2'b10, 64'h0, 0, 16'h0);
        vecs[7] = mk(0, 10'h22,  21'h300,    8'd2, 64'h0, 8'h00, 0, 0, 64'h1111,
                     18'h60, 0, 2'b10, 64'h0, 3, 16'b100);

        awvalid = 1'b1; arvalid = 1'b1; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; arid = '0; araddr = '0; arlen = '0;
        wdata = '0; wstrb = '0; csr_ack = 1'b0; csr_err = 1'b0; csr_rdata = '0;
        rst = 1'b1;
        repeat (3) tick();
        check("reset.outputs_zero", all_outs(), 256'(0));
        awvalid = 1'b0; arvalid = 1'b0;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].t, 0, o);
            e = '{default: 0};
            e.stable = 1'b1; e.resp_same = 1'b1;
            e.csr_addr = vecs[i].e_addr; e.csr_wr = vecs[i].t.wr;
            e.csr_be = vecs[i].t.wstrb; e.csr_wdata = vecs[i].t.wdata;
            e.req_cycles = vecs[i].e_req; e.first_valid = vecs[i].e_req;
            e.id = vecs[i].t.id; e.resp = vecs[i].e_resp; e.rdata = vecs[i].e_rdata;
            e.beats = vecs[i].e_beats; e.rlast_mask = vecs[i].e_mask;
            compare($sformatf("vec%0d", i), vecs[i].t, o, e);
        end

        // Late ack after a timeout must be dropped; the next read returns its own data.
        t = '{wr: 0, id: 10'h0C3, addr: 21'h0A8, len: 8'd0, wdata: '0, wstrb: '0,
              ack_dly: -1, err: 0, rdata_in: 64'h0};
        run_txn(t, 0, o);
        compare("timeout_rd", t, o, model(t));
        repeat (4) tick();
        csr_ack = 1'b1; csr_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (csr_req || bvalid || rvalid) cnt++;
            tick();
        end
        check("late_ack.no_activity", 256'(cnt), 256'(0));
        t = '{wr: 0, id: 10'h0C4, addr: 21'h0B0, len: 8'd0, wdata: '0, wstrb: '0,
              ack_dly: 1, err: 0, rdata_in: 64'h77};
        run_txn(t, 0, o);
        compare("after_late_ack", t, o, model(t));

        // B held off 10 cycles: bvalid/bid/bresp must not move.
        t = '{wr: 1, id: 10'h155, addr: 21'h088, len: 8'd0, wdata: 64'h0F0F, wstrb: 8'h3C,
              ack_dly: 0, err: 0, rdata_in: '0};
        run_txn(t, 10, o);
        compare("bp_write", t, o, model(t));

        // Both channels valid continuously: strict alternation starting with a write.
        do_reset();
        both_ready_cnt = 0;
        last_rd = 1'b1;
        awvalid = 1'b1; awid = 10'h0A1; awaddr = 21'h40; awlen = 8'd0;
        arvalid = 1'b1; arid = 10'h0B2; araddr = 21'h80; arlen = 8'd0;
        for (int g = 0; g < 6; g++) begin
            exp_wr = last_rd;
            hw = 1'b0; hr = 1'b0; n = 0;
            while (!hw && !hr && n < 20) begin
                @(negedge clk);
                hw = awready; hr = arready;
                tick();
                n++;
            end
            if (g == 5) begin
                awvalid = 1'b0; arvalid = 1'b0;
            end
            check($sformatf("arb.grant%0d_is_write", g), 256'(hw), 256'(exp_wr));
            last_rd = !exp_wr;
            t = '{wr: hw, id: hw ? 10'h0A1 : 10'h0B2, addr: hw ? 21'h40 : 21'h80, len: 8'd0,
                  wdata: 64'h1234, wstrb: 8'hFF, ack_dly: 0, err: 0, rdata_in: 64'h4321};
            finish_txn(t, 0, o);
            check($sformatf("arb.txn%0d_id", g), 256'(o.id), 256'(t.id));
            check($sformatf("arb.txn%0d_resp", g), 256'(o.resp), 256'(0));
        end
        check("arb.readies_never_both", 256'(both_ready_cnt), 256'(0));

        // Reset during an outstanding CSR access drops it without a response.
        t = '{wr: 0, id: 10'h066, addr: 21'h1C0, len: 8'd0, wdata: '0, wstrb: '0,
              ack_dly: -1, err: 0, rdata_in: '0};
        addr_phase(t);
        @(negedge clk);
        check("rst_mid.req_active", 256'(csr_req), 256'(1));
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid.outputs_zero", all_outs(), 256'(0));
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (csr_req || bvalid || rvalid) cnt++;
            bready = 1'b1; rready = 1'b1;
            tick();
        end
        check("rst_mid.no_response", 256'(cnt), 256'(0));

        // Randomized isolated transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            t.wr       = bit'($urandom_range(0, 1));
            t.id       = IDW'($urandom);
            t.addr     = AW'($urandom);
            t.len      = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
            t.wdata    = {$urandom, $urandom};
            t.wstrb    = BEW'($urandom);
            t.ack_dly  = $urandom_range(0, 10);
            t.err      = ($urandom_range(0, 3) == 0);
            t.rdata_in = {$urandom, $urandom};
            run_txn(t, $urandom_range(0, 2), o);
            compare($sformatf("rnd%0d", i), t, o, model(t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
